arith_seq_unit: RTL and testbench
=================================

# arith_seq_unit

Parametrised, self-sequenced two-operand arithmetic unit. It combines operand registers, an add/sub arithmetic stage, fixed right-shifters and a result stage with its own controller, so no external micro-op strobes are needed. A `start`/`done` handshake launches one of four selectable recipes. Each run has a fixed 3-cycle latency, and `out` is held until the next result. It sits between the FIFO read side and downstream consumers wherever the team needs a sum, average or scaled difference of two words.

## Interface
- `WIDTH`, 5: operand and result width in bits (≥4).
- `SH_LO`, 1: low shift amount (<WIDTH).
- `SH_HI`, 3: high shift amount (SH_LO < SH_HI < WIDTH).

- `clk`  in  1  rising-edge clock.
- `clear`  in  1  reset, asynchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `mode`  in  2  recipe select; captured with `start`.
- `in1`  in  WIDTH  operand A; captured with `start`.
- `in2`  in  WIDTH  operand B; captured with `start`.
- `out`  out  WIDTH  registered result; holds until the next completion.
- `ovf`  out  1  registered carry/borrow flag for `out`.
- `busy`  out  1  high from acceptance until completion.
- `done`  out  1  one-cycle pulse when `out`/`ovf` update.

## Operation
- Reset clears state, operand and temp registers, and all outputs:
  - state → IDLE; A, B, T, c → 0.
  - `out`=0, `ovf`=0, `busy`=0, `done`=0.
- Reset is effective mid-run; an aborted run never asserts `done`.
- FSM states: IDLE → EX1 → EX2 → IDLE.
- **IDLE**
  - `done` is low here, except in the cycle immediately after EX2.
  - If `start`=1: A←in1, B←in2, M←mode, `busy`←1, go to EX1.
  - Otherwise stay in IDLE.
- **EX1**
  - If M=3: {c,T} = {0,A} − {0,B}, so c is the borrow.
  - Otherwise: {c,T} = A + B, computed at WIDTH+1 bits.
  - Register T and c; go to EX2.
- **EX2**: register the result, `done`←1, `busy`←0, go to IDLE. Results by mode:
  - M=0, average: `out` = {c,T} >> SH_LO, truncated to WIDTH bits; `ovf`=0. With SH_LO=1 this is the exact floor average.
  - M=1, scaled sum: `out` = (T + (T >> SH_HI)) mod 2^WIDTH; `ovf` = c OR carry of that add.
  - M=2, shift difference: `out` = (T >> SH_LO) − (T >> SH_HI); never negative; `ovf` = c.
  - M=3, difference: `out` = T (A−B mod 2^WIDTH); `ovf` = borrow (A<B).
- All arithmetic is unsigned. Shifts are logical and zero-fill.
- `start` asserted while `busy`=1 is ignored, not queued. Changes to `mode`/`in1`/`in2` after acceptance have no effect on the run.
- No tri-state buses: all internal steering is by multiplexers.

## Timing
- Acceptance at edge n (IDLE, `start`=1): `busy`=1 after edge n.
- Edge n+1: T and c are registered.
- Edge n+2: `out`/`ovf` update, `done`=1, `busy`=0.
- Edge n+3: `done` returns to 0. A `start` high at edge n+3 is accepted, giving a throughput of one run per 3 cycles.
- `done` and `busy` are never high in the same cycle.
- Simultaneous `clear` and `start`: `clear` wins; nothing is accepted.

## Test plan
- Defaults (WIDTH=5), M=0, in1=31, in2=31 → after 3 edges `out`=31, `ovf`=0, `done` pulses once.
- M=1, in1=10, in2=6 → `out`=18, `ovf`=0. M=1, in1=20, in2=15 → `out`=3, `ovf`=1 (sum 35 wraps).
- M=2, in1=20, in2=4 → `out`=9 (12−3). M=3, in1=3, in2=5 → `out`=30, `ovf`=1. M=3, in1=9, in2=4 → `out`=5, `ovf`=0.
- Back-to-back:
  - Hold `start`=1 with changing operands → runs are accepted at edges n, n+3, n+6.
  - The operand change during EX1 is ignored; each `done` carries the correct result.
- Reset and hold:
  - Assert `clear` during EX1 → `out`=0, `ovf`=0, `busy`=0; no `done` follows.
  - After a completed run, with no `start`, `out` holds its value for ≥10 cycles.
- Parameter sweep: WIDTH=8, SH_LO=2, SH_HI=5, M=1, in1=200, in2=100.
  - T=44, c=1, T>>5=1 → `out`=45, `ovf`=1.
  - Also a randomised comparison against a reference model over all modes.

Source files
------------

// File: rtl/arith_seq_unit.sv
// ============================================================================
// Module      : arith_seq_unit
// Description : Self-sequenced two-operand unit (average / scaled sum /
//               shift difference / difference), fixed 3-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_seq_unit #(
  parameter int WIDTH = 5,
  parameter int SH_LO = 1,
  parameter int SH_HI = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_mode_avg = 2'd0;
  localparam logic [1:0] c_mode_scl = 2'd1;
  localparam logic [1:0] c_mode_shd = 2'd2;
  localparam logic [1:0] c_mode_dif = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EX1  = 2'd1,
    S_EX2  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_m;
  logic [WIDTH-1:0] r_t;
  logic             r_c;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_ex1;
  logic [WIDTH:0]   w_scl;
  logic [WIDTH-1:0] w_res;
  logic             w_res_ovf;

  // EX1: the single add/sub stage; the top bit is carry for add, borrow for sub
  always_comb begin
    w_ex1 = '0;
    if (r_m == c_mode_dif) begin
      w_ex1 = {1'b0, r_a} - {1'b0, r_b};
    end else begin
      w_ex1 = {1'b0, r_a} + {1'b0, r_b};
    end
  end

  // EX2: result selection from the registered temp {c,T}
  always_comb begin
    w_scl     = {1'b0, r_t} + {1'b0, (r_t >> SH_HI)};
    w_res     = '0;
    w_res_ovf = 1'b0;
    case (r_m)
      c_mode_avg: begin
        w_res     = WIDTH'({r_c, r_t} >> SH_LO);
        w_res_ovf = 1'b0;
      end
      c_mode_scl: begin
        w_res     = w_scl[WIDTH-1:0];
        w_res_ovf = r_c | w_scl[WIDTH];
      end
      c_mode_shd: begin
        // T>>SH_LO is always >= T>>SH_HI, so this never wraps
        w_res     = (r_t >> SH_LO) - (r_t >> SH_HI);
        w_res_ovf = r_c;
      end
      default: begin
        w_res     = r_t;
        w_res_ovf = r_c;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_t     <= '0;
      r_c     <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= in1;
            r_b     <= in2;
            r_m     <= mode;
            r_busy  <= 1'b1;
            r_state <= S_EX1;
          end
        end
        S_EX1: begin
          r_t     <= w_ex1[WIDTH-1:0];
          r_c     <= w_ex1[WIDTH];
          r_state <= S_EX2;
        end
        S_EX2: begin
          r_out   <= w_res;
          r_ovf   <= w_res_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_arith_seq_unit.sv
// ============================================================================
// Module      : tb_arith_seq_unit
// Description : Directed vector table plus multi-cycle sequences for
//               arith_seq_unit at default and 8-bit parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_seq_unit;

  logic clk;
  logic clear;

  logic       start5;
  logic [1:0] mode5;
  logic [4:0] in1_5;
  logic [4:0] in2_5;
  logic [4:0] out5;
  logic       ovf5;
  logic       busy5;
  logic       done5;

  logic       start8;
  logic [1:0] mode8;
  logic [7:0] in1_8;
  logic [7:0] in2_8;
  logic [7:0] out8;
  logic       ovf8;
  logic       busy8;
  logic       done8;

  int errors;
  int checks;

  arith_seq_unit dut5 (
    .clk  (clk),
    .clear(clear),
    .start(start5),
    .mode (mode5),
    .in1  (in1_5),
    .in2  (in2_5),
    .out  (out5),
    .ovf  (ovf5),
    .busy (busy5),
    .done (done5)
  );

  arith_seq_unit #(.WIDTH(8), .SH_LO(2), .SH_HI(5)) dut8 (
    .clk  (clk),
    .clear(clear),
    .start(start8),
    .mode (mode8),
    .in1  (in1_8),
    .in2  (in2_8),
    .out  (out8),
    .ovf  (ovf8),
    .busy (busy8),
    .done (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] exp_out;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full run on the 5-bit instance, checking handshake timing and result
  task automatic run5(input logic [1:0] m, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] eo, input logic eovf, input string name);
    start5 = 1'b1; mode5 = m; in1_5 = a; in2_5 = b;
    @(negedge clk);
    start5 = 1'b0;
    mode5 = ~m; in1_5 = ~a; in2_5 = ~b;
    chk({name, " busy_ex1"}, {busy5, done5}, 2'b10);
    @(negedge clk);
    chk({name, " busy_ex2"}, {busy5, done5}, 2'b10);
    @(negedge clk);
    chk({name, " done"}, {busy5, done5}, 2'b01);
    chk({name, " out"}, out5, eo);
    chk({name, " ovf"}, ovf5, eovf);
  endtask

  function automatic void model8(input int m, input int a, input int b,
                                 output int eo, output int eovf);
    int s, t, c, v;
    if (m == 3) begin
      eo = (a - b) & 255;
      eovf = (a < b) ? 1 : 0;
    end else begin
      s = a + b;
      t = s % 256;
      c = (s > 255) ? 1 : 0;
      if (m == 0) begin
        eo = (s / 4) % 256;
        eovf = 0;
      end else if (m == 1) begin
        v = t + t / 32;
        eo = v % 256;
        eovf = (c == 1 || v > 255) ? 1 : 0;
      end else begin
        eo = t / 4 - t / 32;
        eovf = c;
      end
    end
  endfunction

  task automatic run8(input int m, input int a, input int b, input string name);
    int eo, eovf;
    model8(m, a, b, eo, eovf);
    start8 = 1'b1; mode8 = 2'(m); in1_8 = 8'(a); in2_8 = 8'(b);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, " done"}, {busy8, done8}, 2'b01);
    chk({name, " out"}, out8, eo);
    chk({name, " ovf"}, ovf8, eovf);
  endtask

  initial begin
    int held;
    int spur;
    errors = 0;
    checks = 0;

    vecs[0]  = '{2'd0, 5'd31, 5'd31, 5'd31, 1'b0};
    vecs[1]  = '{2'd1, 5'd10, 5'd6,  5'd18, 1'b0};
    vecs[2]  = '{2'd1, 5'd20, 5'd15, 5'd3,  1'b1};
    vecs[3]  = '{2'd2, 5'd20, 5'd4,  5'd9,  1'b0};
    vecs[4]  = '{2'd3, 5'd3,  5'd5,  5'd30, 1'b1};
    vecs[5]  = '{2'd3, 5'd9,  5'd4,  5'd5,  1'b0};
    vecs[6]  = '{2'd0, 5'd10, 5'd5,  5'd7,  1'b0};
    vecs[7]  = '{2'd0, 5'd0,  5'd1,  5'd0,  1'b0};
    vecs[8]  = '{2'd2, 5'd31, 5'd0,  5'd12, 1'b0};
    vecs[9]  = '{2'd2, 5'd31, 5'd31, 5'd12, 1'b1};
    vecs[10] = '{2'd1, 5'd31, 5'd31, 5'd1,  1'b1};
    vecs[11] = '{2'd3, 5'd0,  5'd0,  5'd0,  1'b0};

    clear = 1'b1;
    start5 = 1'b0; mode5 = '0; in1_5 = '0; in2_5 = '0;
    start8 = 1'b0; mode8 = '0; in1_8 = '0; in2_8 = '0;
    repeat (2) @(negedge clk);
    chk("reset out5", out5, 0);
    chk("reset flags5", {ovf5, busy5, done5}, 0);
    chk("reset out8", out8, 0);
    chk("reset flags8", {ovf8, busy8, done8}, 0);
    clear = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run5(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_ovf,
           $sformatf("vec%0d", i));
    end
    @(negedge clk);
    chk("done clears", done5, 0);

    // Back-to-back: start held high, operands change while busy
    start5 = 1'b1; mode5 = 2'd1; in1_5 = 5'd10; in2_5 = 5'd6;
    @(negedge clk);
    chk("b2b busy1", {busy5, done5}, 2'b10);
    mode5 = 2'd3; in1_5 = 5'd20; in2_5 = 5'd15;
    @(negedge clk);
    mode5 = 2'd0; in1_5 = 5'd1; in2_5 = 5'd2;
    @(negedge clk);
    chk("b2b done1", {busy5, done5}, 2'b01);
    chk("b2b out1", out5, 18);
    mode5 = 2'd3; in1_5 = 5'd3; in2_5 = 5'd5;
    @(negedge clk);
    chk("b2b busy2", {busy5, done5}, 2'b10);
    mode5 = 2'd1; in1_5 = 5'd31; in2_5 = 5'd31;
    @(negedge clk);
    mode5 = 2'd0; in1_5 = 5'd7; in2_5 = 5'd7;
    @(negedge clk);
    chk("b2b done2", {busy5, done5}, 2'b01);
    chk("b2b out2", {ovf5, out5}, {1'b1, 5'd30});
    mode5 = 2'd2; in1_5 = 5'd20; in2_5 = 5'd4;
    @(negedge clk);
    chk("b2b busy3", {busy5, done5}, 2'b10);
    start5 = 1'b0;
    mode5 = 2'd3; in1_5 = 5'd0; in2_5 = 5'd31;
    repeat (2) @(negedge clk);
    chk("b2b done3", {busy5, done5}, 2'b01);
    chk("b2b out3", {ovf5, out5}, {1'b0, 5'd9});

    // Hold: no start for 10 cycles, result must persist
    held = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out5 != 5'd9 || ovf5 != 1'b0 || done5 != 1'b0) held = 0;
    end
    chk("hold out", held, 1);

    // Clear during EX1 aborts the run with no done
    start5 = 1'b1; mode5 = 2'd1; in1_5 = 5'd10; in2_5 = 5'd6;
    @(negedge clk);
    start5 = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("abort out", out5, 0);
    chk("abort flags", {ovf5, busy5, done5}, 0);
    clear = 1'b0;
    spur = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done5 || busy5) spur = 1;
    end
    chk("abort no done", spur, 0);

    // Clear and start together: clear wins
    clear = 1'b1; start5 = 1'b1; mode5 = 2'd0; in1_5 = 5'd4; in2_5 = 5'd4;
    @(negedge clk);
    clear = 1'b0; start5 = 1'b0;
    @(negedge clk);
    chk("clear beats start", busy5, 0);

    // Parameter sweep instance
    run8(1, 200, 100, "w8 scl");
    run8(0, 255, 255, "w8 avg");
    run8(2, 250, 10, "w8 shd");
    run8(3, 17, 200, "w8 dif");
    for (int i = 0; i < 20; i++) begin
      run8(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), $sformatf("w8 rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
